// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline constants: opcode/funct encodings and the MDU timer state type.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_SRA    = 6'b000011;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIV    = 6'b011010;
  localparam logic [5:0] F_DIVU   = 6'b011011;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_busy_timer.sv
// Tracks the fixed-latency MDU busy window: RUN until start, then BUSY for MDU_LAT cycles.
module mdu_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int unsigned CntW = $clog2(MDU_LAT + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = CntW'(MDU_LAT - 1);
        end
      end
      ST_BUSY: begin
        // cnt==0 marks the last busy cycle; the result is valid the cycle after.
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == ST_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / HI-LO hazard detection, branch flush and MDU issue control for the 5-stage core.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ifid_reg,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       rs_used, rt_used, is_md, is_mf;
  logic       load_use, md_hold, stall;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  assign op    = ifid_reg[31:26];
  assign rs    = ifid_reg[25:21];
  assign rt    = ifid_reg[20:16];
  assign funct = ifid_reg[5:0];

  always_comb begin
    rs_used = 1'b1;
    if (op == OP_J || op == OP_JAL || op == OP_LUI) begin
      rs_used = 1'b0;
    end else if (op == OP_RTYPE && (funct == F_SLL || funct == F_SRL || funct == F_SRA)) begin
      rs_used = 1'b0;
    end
  end

  assign rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                   (op == OP_SW) || (op == OP_SB);

  assign is_md = (op == OP_RTYPE) &&
                 (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
  assign is_mf = (op == OP_RTYPE) && (funct == F_MFHI || funct == F_MFLO);

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((rs_used && rs == idex_rt) || (rt_used && rt == idex_rt));

  assign md_hold = mdu_busy && (is_md || is_mf);
  assign stall   = (load_use || md_hold) && !branch_taken;

  // A flush during BUSY leaves the timer alone: the issuing op is older than the branch.
  assign mdu_start = !mdu_busy && is_md && !load_use && !branch_taken;

  mdu_busy_timer #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_busy_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdu_start),
    .busy (mdu_busy)
  );

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MDU_LAT=4; expected values are hand-derived.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] ifid_reg;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start, mdu_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(
    .MDU_LAT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifid_reg    (ifid_reg),
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .branch_taken(branch_taken),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .mdu_start   (mdu_start),
    .mdu_busy    (mdu_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {32'h0040_0004, 6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [63:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {32'h0040_0004, op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic pw, input logic iw, input logic fl,
                          input logic bb, input logic ms, input logic mb);
    #1;
    chk({tag, ".pc_write"},    32'(pc_write),    32'(pw));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(iw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bb));
    chk({tag, ".mdu_start"},   32'(mdu_start),   32'(ms));
    chk({tag, ".mdu_busy"},    32'(mdu_busy),    32'(mb));
  endtask

  logic [63:0] nop, add_356, lui_5, sll_25, mult_89, mfhi_10;

  initial begin
    nop     = {32'h0040_0004, 32'h0};
    add_356 = rtype(5'd5, 5'd6, 5'd3, 5'd0, 6'b100000);
    lui_5   = itype(6'b001111, 5'd0, 5'd5, 16'h1234);
    sll_25  = rtype(5'd0, 5'd5, 5'd2, 5'd2, 6'b000000);
    mult_89 = rtype(5'd8, 5'd9, 5'd0, 5'd0, 6'b011000);
    mfhi_10 = rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'b010000);

    rst_n = 1'b0; ifid_reg = nop; idex_memread = 1'b0; idex_rt = 5'd0; branch_taken = 1'b0;
    #12;
    chk_ctrl("reset", 1, 1, 0, 0, 0, 0);
    chk("reset.stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) next_cycle();
    chk_ctrl("nop_stream", 1, 1, 0, 0, 0, 0);
    chk("nop_stream.stall_cycles", stall_cycles, 32'd0);

    // Load-use through rs.
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_reg = add_356;
    chk_ctrl("lu_rs", 0, 0, 0, 1, 0, 0);
    next_cycle();
    idex_memread = 1'b0;
    chk_ctrl("lu_rs_release", 1, 1, 0, 0, 0, 0);
    chk("lu_rs.stall_cycles", stall_cycles, 32'd1);

    // Load-use through rt of an R-type.
    idex_memread = 1'b1; idex_rt = 5'd6;
    chk_ctrl("lu_rt_add", 0, 0, 0, 1, 0, 0);
    next_cycle();
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_reg = lui_5;
    chk_ctrl("lui_no_hazard", 1, 1, 0, 0, 0, 0);
    chk("lu_rt_add.stall_cycles", stall_cycles, 32'd2);
    next_cycle();
    idex_rt = 5'd0; ifid_reg = sll_25;
    chk_ctrl("sll_rt0", 1, 1, 0, 0, 0, 0);
    next_cycle();
    idex_rt = 5'd5;
    chk_ctrl("sll_rt5", 0, 0, 0, 1, 0, 0);
    next_cycle();
    idex_memread = 1'b0; ifid_reg = nop;
    chk("sll.stall_cycles", stall_cycles, 32'd3);

    // mult at cycle 0, mfhi at cycle 1 held through cycle 4, released at cycle 5.
    next_cycle();
    ifid_reg = mult_89;
    chk_ctrl("mult_c0", 1, 1, 0, 0, 1, 0);
    next_cycle();
    ifid_reg = mfhi_10;
    chk_ctrl("mfhi_c1", 0, 0, 0, 1, 0, 1);
    next_cycle();
    chk_ctrl("mfhi_c2", 0, 0, 0, 1, 0, 1);
    next_cycle();
    chk_ctrl("mfhi_c3", 0, 0, 0, 1, 0, 1);
    next_cycle();
    chk_ctrl("mfhi_c4", 0, 0, 0, 1, 0, 1);
    next_cycle();
    chk_ctrl("mfhi_c5", 1, 1, 0, 0, 0, 0);
    chk("mfhi.stall_cycles", stall_cycles, 32'd7);
    next_cycle();
    ifid_reg = nop;

    // Branch outranks a load-use stall.
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_reg = add_356; branch_taken = 1'b1;
    chk_ctrl("br_over_lu", 1, 1, 1, 1, 0, 0);
    next_cycle();
    idex_memread = 1'b0; ifid_reg = mult_89;
    chk_ctrl("br_over_mult", 1, 1, 1, 1, 0, 0);
    chk("br_over_lu.stall_cycles", stall_cycles, 32'd7);
    next_cycle();
    branch_taken = 1'b0; ifid_reg = nop;
    chk_ctrl("br_no_issue", 1, 1, 0, 0, 0, 0);
    chk("br_over_mult.stall_cycles", stall_cycles, 32'd7);

    // Flush during BUSY keeps the MDU running.
    next_cycle();
    ifid_reg = mult_89;
    chk_ctrl("mult_b0", 1, 1, 0, 0, 1, 0);
    next_cycle();
    ifid_reg = nop; branch_taken = 1'b1;
    chk_ctrl("br_in_busy", 1, 1, 1, 1, 0, 1);
    next_cycle();
    branch_taken = 1'b0;
    chk_ctrl("busy_after_br", 1, 1, 0, 0, 0, 1);

    // Asynchronous reset mid-BUSY.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.mdu_busy", 32'(mdu_busy), 32'd0);
    chk("async_rst.stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    ifid_reg = mfhi_10;
    chk_ctrl("mfhi_after_rst", 1, 1, 0, 0, 0, 0);
    next_cycle();
    chk("mfhi_after_rst.stall_cycles", stall_cycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It reads the IF/ID register, the ID/EX load status and the EX branch outcome. From these it drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble. It also issues mult/div to the fixed-latency multiply/divide unit (MDU) and tracks the MDU's busy window so that dependent HI/LO reads stall.

## Interface
Parameters:
- MDU_LAT, 32, MDU busy cycles after issue; legal range 1..64.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ifid_reg  in  64  IF/ID register; [31:0] instruction, [63:32] PC+4.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  force NOP into ID/EX.
- mdu_start  out  1  one-cycle MDU issue strobe.
- mdu_busy  out  1  MDU result not yet valid.
- stall_cycles  out  32  saturating count of stalled cycles.

## Operation
- Decode fields from ifid_reg: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- rs_used: true for all opcodes except j/jal (000010, 000011) and lui (001111). It is also false for op 0 with funct 000000, 000010 or 000011 (shift by shamt).
- rt_used: true for op 000000, 000100, 000101, 101011, 101000.
- is_md: op 0 with funct 011000, 011001, 011010 or 011011.
- is_mf: op 0 with funct 010000 or 010010.
- load_use = idex_memread & idex_rt≠0 & ((rs_used & rs==idex_rt) | (rt_used & rt==idex_rt)).
- FSM states: RUN and BUSY. Counter cnt has width $clog2(MDU_LAT+1).
- md_hold = BUSY & (is_md | is_mf).
- stall = (load_use | md_hold) & ~branch_taken.
- When stall is high: pc_write=0, ifid_write=0, idex_bubble=1.
- When branch_taken is high: ifid_flush=1 and idex_bubble=1; pc_write and ifid_write stay 1. Flush outranks every stall.
- mdu_start = RUN & is_md & ~load_use & ~branch_taken.
- Transition RUN→BUSY on mdu_start, loading cnt=MDU_LAT-1.
- In BUSY, cnt decrements each cycle. At cnt==0 the next state is RUN.
- mdu_busy = (state==BUSY).
- A flush during BUSY does not cancel the MDU: the issuing instruction was older than the branch.
- stall_cycles increments every cycle that stall=1 and saturates at 0xFFFFFFFF.
- Register 0 never creates a load-use hazard.

## Timing
- pc_write, ifid_write, ifid_flush, idex_bubble and mdu_start are combinational from the current state and inputs, so they act in the same cycle.
- Reset values: state=RUN, cnt=0, stall_cycles=0. With ifid_reg as a NOP, this gives pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, mdu_start=0, mdu_busy=0.
- Load-use stall lasts exactly 1 cycle. The next cycle the load has moved past EX, so idex_memread is 0 for that slot.
- mult issued in cycle t: mdu_busy is high in cycles t+1 .. t+MDU_LAT. An mfhi in ID during that window stalls. It proceeds in cycle t+MDU_LAT+1.
- With MDU_LAT=1, BUSY lasts a single cycle.
- Reset asserted mid-BUSY returns the block to RUN immediately and asynchronously; mdu_busy drops to 0.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_J, OP_JAL, OP_LUI;
  - funct constants F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_SLL, F_SRL, F_SRA;
  - the state encoding ST_RUN and ST_BUSY.
- One sub-module, mdu_busy_timer, holds the FSM and down-counter. Interface: start in; busy out; parameter MDU_LAT.
- Decode logic and the stall counter live in the top module.

## Test plan
- Reset then NOP stream: all enables 1, flush/bubble 0, stall_cycles=0 after 10 cycles.
- Load-use: idex_memread=1, idex_rt=5, ID holds add $3,$5,$6. Expect a 1-cycle stall (pc_write=0, idex_bubble=1) and stall_cycles=1.
- Same load with ID holding lui $5 or sll $2,$5,2 (rt hazard only via rt_used), idex_rt=0: check that only sll with rt=5 stalls.
- MDU_LAT=4: mult in cycle 0 gives mdu_start=1 at cycle 0 and mdu_busy in cycles 1–4. mfhi arriving at cycle 1 stalls 4 cycles and is released at cycle 5.
- branch_taken while load_use is true and while mult is in ID: ifid_flush=1, pc_write=1, mdu_start=0, no stall counted.
- rst_n pulsed low mid-BUSY (asynchronous, between clock edges): mdu_busy falls immediately; after release, mfhi does not stall.
